// File: rtl/phase_diff_peak.sv
// Peak-bin search over framed polar FFT beats with wrapped phase differences (channels 1.. vs channel 0).
// Optional macro PDP_MAG_SUM_EN: peak metric is the sum of all channel magnitudes instead of channel 0 alone.
module phase_diff_peak #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FFT_SIZE   = 1024,
    parameter int MIN_BIN    = 1,
    parameter int MAX_BIN    = 511,
    parameter int MAG_THRESH = 64,
    parameter int PI_Q       = 25736,
    localparam int BIN_W     = $clog2(FFT_SIZE)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           valid_in,
    input  logic                           last_in,
    output logic [BIN_W-1:0]               bin_out,
    output logic [15:0]                    mag_out,
    output logic [(CHANNELS-1)*16-1:0]     phase_out,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic                           overrun_out
);

`ifdef PDP_MAG_SUM_EN
    localparam int MET_W = 16 + $clog2(CHANNELS);
`else
    localparam int MET_W = 16;
`endif
    localparam int PH_W = CHANNELS * 16;
    localparam int DF_W = (CHANNELS - 1) * 16;

    localparam logic [BIN_W-1:0]   MIN_B  = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0]   MAX_B  = BIN_W'(MAX_BIN);
    localparam logic [BIN_W-1:0]   LAST_B = BIN_W'(FFT_SIZE - 1);
    localparam logic [MET_W-1:0]   THRESH = MET_W'(MAG_THRESH);
    localparam logic signed [16:0] PI_P   = 17'(PI_Q);
    localparam logic signed [16:0] PI_N   = -PI_P;
    localparam logic signed [16:0] TWO_PI = 17'(2 * PI_Q);

    // Beat unpacking and peak metric
    logic [PH_W-1:0]  w_phases;
    logic [MET_W-1:0] w_metric;
    logic             w_unused_data;

    always_comb begin
        w_phases = '0;
        for (int i = 0; i < CHANNELS; i++)
            w_phases[16*i +: 16] = data_in[DATA_WIDTH*i + 16 +: 16];
    end

`ifdef PDP_MAG_SUM_EN
    always_comb begin
        w_metric = '0;
        for (int i = 0; i < CHANNELS; i++)
            w_metric = w_metric + MET_W'(data_in[DATA_WIDTH*i +: 16]);
    end
`else
    assign w_metric = data_in[15:0];
`endif

    assign w_unused_data = ^data_in;

    // Accumulator: running peak over the current frame
    logic [BIN_W-1:0] r_bin;
    logic             r_seen;
    logic [MET_W-1:0] r_max;
    logic [BIN_W-1:0] r_cap_bin;
    logic [PH_W-1:0]  r_cap_ph;

    logic             w_eligible;
    logic             w_take;
    logic             w_end;
    logic             w_seen_nx;
    logic [MET_W-1:0] w_max_nx;
    logic [BIN_W-1:0] w_bin_nx;
    logic [PH_W-1:0]  w_ph_nx;

    assign w_eligible = (r_bin >= MIN_B) && (r_bin <= MAX_B);
    // Strict '>' keeps the lowest bin on ties.
    assign w_take     = valid_in && w_eligible && (!r_seen || (w_metric > r_max));
    assign w_end      = valid_in && (last_in || (r_bin == LAST_B));
    assign w_seen_nx  = r_seen || w_take;
    assign w_max_nx   = w_take ? w_metric : r_max;
    assign w_bin_nx   = w_take ? r_bin    : r_cap_bin;
    assign w_ph_nx    = w_take ? w_phases : r_cap_ph;

    // Completed-frame result, valid for exactly one cycle after the frame-end beat
    logic             r_f_valid;
    logic [BIN_W-1:0] r_f_bin;
    logic [MET_W-1:0] r_f_met;
    logic [PH_W-1:0]  r_f_ph;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_bin     <= '0;
            r_seen    <= 1'b0;
            r_max     <= '0;
            r_cap_bin <= '0;
            r_cap_ph  <= '0;
            r_f_valid <= 1'b0;
            r_f_bin   <= '0;
            r_f_met   <= '0;
            r_f_ph    <= '0;
        end else begin
            r_f_valid <= 1'b0;
            if (valid_in) begin
                r_cap_bin <= w_bin_nx;
                r_cap_ph  <= w_ph_nx;
                if (w_end) begin
                    r_bin     <= '0;
                    r_seen    <= 1'b0;
                    r_max     <= '0;
                    r_f_valid <= w_seen_nx && (w_max_nx >= THRESH);
                    r_f_bin   <= w_bin_nx;
                    r_f_met   <= w_max_nx;
                    r_f_ph    <= w_ph_nx;
                end else begin
                    r_bin  <= r_bin + BIN_W'(1);
                    r_seen <= w_seen_nx;
                    r_max  <= w_max_nx;
                end
            end
        end
    end

    // Wrapped difference: 17-bit raw diff folded once into [-PI_Q, PI_Q).
    function automatic logic [15:0] wrap_diff(input logic [15:0] ph_k, input logic [15:0] ph_0);
        logic signed [16:0] d;
        d = $signed({ph_k[15], ph_k}) - $signed({ph_0[15], ph_0});
        if (d >= PI_P)
            d = d - TWO_PI;
        else if (d < PI_N)
            d = d + TWO_PI;
        return d[15:0];
    endfunction

    logic [DF_W-1:0] w_diff;
    logic [15:0]     w_f_mag;

    always_comb begin
        w_diff = '0;
        for (int k = 1; k < CHANNELS; k++)
            w_diff[16*(k-1) +: 16] = wrap_diff(r_f_ph[16*k +: 16], r_f_ph[15:0]);
    end

`ifdef PDP_MAG_SUM_EN
    assign w_f_mag = (r_f_met > MET_W'(17'h0FFFF)) ? 16'hFFFF : r_f_met[15:0];
`else
    assign w_f_mag = r_f_met;
`endif

    // Output handshake: data is stable while valid_out && !ready_in; a transfer happens on
    // valid_out && ready_in, and a new result may load in that same cycle. A result arriving
    // while the held one is not accepted is dropped and flagged with a one-cycle overrun pulse.
    logic             r_valid_out;
    logic [BIN_W-1:0] r_bin_out;
    logic [15:0]      r_mag_out;
    logic [DF_W-1:0]  r_phase_out;
    logic             r_overrun;
    logic             w_accept;
    logic             w_load;

    assign w_accept = r_valid_out && ready_in;
    assign w_load   = r_f_valid && (!r_valid_out || ready_in);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid_out <= 1'b0;
            r_bin_out   <= '0;
            r_mag_out   <= '0;
            r_phase_out <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= r_f_valid && r_valid_out && !ready_in;
            if (w_load) begin
                r_valid_out <= 1'b1;
                r_bin_out   <= r_f_bin;
                r_mag_out   <= w_f_mag;
                r_phase_out <= w_diff;
            end else if (w_accept) begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign valid_out   = r_valid_out;
    assign bin_out     = r_bin_out;
    assign mag_out     = r_mag_out;
    assign phase_out   = r_phase_out;
    assign overrun_out = r_overrun;

endmodule

// File: tb/tb_phase_diff_peak.sv
// Self-checking bench for phase_diff_peak: directed frames plus randomized frames against a frame-level model.
module tb_phase_diff_peak;
    localparam int CH   = 4;
    localparam int DW   = 32;
    localparam int FFT  = 16;
    localparam int MINB = 1;
    localparam int MAXB = 7;
    localparam int THR  = 64;
    localparam int PIQ  = 25736;
    localparam int BW   = $clog2(FFT);
    localparam int PW   = (CH - 1) * 16;
    localparam int EW   = BW + 16 + PW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH*DW-1:0] data_in = '0;
    logic            valid_in = 1'b0;
    logic            last_in = 1'b0;
    logic            ready_in = 1'b1;
    logic [BW-1:0]   bin_out;
    logic [15:0]     mag_out;
    logic [PW-1:0]   phase_out;
    logic            valid_out;
    logic            overrun_out;

    phase_diff_peak #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .FFT_SIZE(FFT), .MIN_BIN(MINB),
        .MAX_BIN(MAXB), .MAG_THRESH(THR), .PI_Q(PIQ)
    ) dut (
        .clk_in(clk), .rst_in(rst), .data_in(data_in), .valid_in(valid_in),
        .last_in(last_in), .bin_out(bin_out), .mag_out(mag_out),
        .phase_out(phase_out), .valid_out(valid_out), .ready_in(ready_in),
        .overrun_out(overrun_out)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;
    int overrun_cnt = 0;
    logic [EW-1:0] exp_q[$];
    int fm[CH][FFT];
    int fp[CH][FFT];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard / monitor: sampled on the falling edge
    logic          prev_hold = 1'b0;
    logic [EW-1:0] prev_out = '0;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (overrun_out) overrun_cnt++;
            if (prev_hold) begin
                check("hold_valid", valid_out, 1'b1);
                check("hold_data", {bin_out, mag_out, phase_out}, prev_out);
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", valid_out, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_bin", bin_out, e[EW-1 -: BW]);
                    check("result_mag", mag_out, e[PW +: 16]);
                    check("result_phase", phase_out, e[PW-1:0]);
                end
            end
            prev_hold = valid_out && !ready_in;
            prev_out  = {bin_out, mag_out, phase_out};
        end
    end

    // Reference model
    task automatic push_exp(input int bin, input int mag, input logic [PW-1:0] ph);
        exp_q.push_back({BW'(bin), 16'(mag), ph});
    endtask

    function automatic int metric(input int b);
        int m;
`ifdef PDP_MAG_SUM_EN
        m = 0;
        for (int c = 0; c < CH; c++) m += fm[c][b];
`else
        m = fm[0][b];
`endif
        return m;
    endfunction

    task automatic model_frame(input int n, input bit push);
        int best;
        int best_met;
        int d;
        logic [PW-1:0] ph;
        best = -1;
        best_met = 0;
        for (int b = 0; b < n; b++) begin
            if (b >= MINB && b <= MAXB) begin
                if (best < 0 || metric(b) > best_met) begin
                    best = b;
                    best_met = metric(b);
                end
            end
        end
        if (push && best >= 0 && best_met >= THR) begin
            ph = '0;
            for (int k = 1; k < CH; k++) begin
                d = fp[k][best] - fp[0][best];
                if (d >= PIQ) d -= 2 * PIQ;
                else if (d < -PIQ) d += 2 * PIQ;
                ph[16*(k-1) +: 16] = 16'(d);
            end
            push_exp(best, (best_met > 65535) ? 65535 : best_met, ph);
        end
    endtask

    // Driver tasks: inputs change 1ns after the rising edge
    task automatic clear_frame();
        for (int c = 0; c < CH; c++)
            for (int b = 0; b < FFT; b++) begin
                fm[c][b] = (c == 0) ? 10 : 0;
                fp[c][b] = 0;
            end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input int b, input bit last);
        for (int c = 0; c < CH; c++)
            data_in[DW*c +: DW] = {16'(fp[c][b]), 16'(fm[c][b])};
        valid_in = 1'b1;
        last_in  = last;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit use_last, input int gap);
        for (int b = 0; b < n; b++) begin
            drive_beat(b, use_last && (b == n - 1));
            if (b < n - 1) idle($urandom_range(0, gap));
        end
    endtask

    int  n_beats;
    bit  use_last;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", valid_out, 1'b0);
        check("rst_bin", bin_out, '0);
        check("rst_mag", mag_out, '0);
        check("rst_phase", phase_out, '0);
        check("rst_overrun", overrun_out, 1'b0);
        idle(1);

        // Basic peak and two-cycle latency
        clear_frame();
        fm[0][3] = 100;
        fp[1][3] = 4096;
        push_exp(3, 100, {16'(0), 16'(0), 16'(4096)});
        send_frame(8, 1, 0);
        @(negedge clk);
        check("latency_cycle1", valid_out, 1'b0);
        @(negedge clk);
        check("latency_cycle2", valid_out, 1'b1);
        idle(3);

        // Phase wrap cases including a difference of exactly PI_Q
        clear_frame();
        fm[0][3] = 100;
        fp[0][3] = -20000;
        fp[1][3] = 20000;
        fp[2][3] = -20000;
        fp[3][3] = 5736;
        push_exp(3, 100, {16'(-25736), 16'(0), 16'(-11472)});
        send_frame(8, 1, 0);
        idle(3);
        clear_frame();
        fm[0][3] = 100;
        fp[0][3] = 20000;
        fp[1][3] = -20000;
        fp[2][3] = 20000;
        fp[3][3] = 20000;
        push_exp(3, 100, {16'(0), 16'(0), 16'(11472)});
        send_frame(8, 1, 0);
        idle(3);

        // Eligibility window, ties, threshold boundary
        clear_frame();
        fm[0][0] = 200;
        fm[0][9] = 200;
        fm[0][2] = 150;
        fm[0][5] = 150;
        push_exp(2, 150, '0);
        send_frame(12, 1, 0);
        idle(3);
        clear_frame();
        fm[0][4] = 63;
        send_frame(8, 1, 0);
        idle(3);
        clear_frame();
        fm[0][6] = 64;
        push_exp(6, 64, '0);
        send_frame(8, 1, 0);
        idle(3);

        // Backpressure: hold, overrun drop, seamless replace
        ready_in = 1'b0;
        clear_frame();
        fm[0][1] = 100;
        model_frame(8, 1);
        send_frame(8, 1, 0);
        clear_frame();
        fm[0][2] = 120;
        model_frame(8, 0);
        send_frame(8, 1, 0);
        clear_frame();
        fm[0][5] = 130;
        model_frame(8, 1);
        send_frame(8, 1, 0);
        ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("seamless_valid", valid_out, 1'b1);
        check("seamless_bin", bin_out, BW'(5));
        idle(3);

        // Frame end by bin count, then counter restart
        clear_frame();
        fm[0][6] = 100;
        model_frame(FFT, 1);
        send_frame(FFT, 0, 0);
        clear_frame();
        fm[0][2] = 90;
        model_frame(8, 1);
        send_frame(8, 1, 0);
        idle(3);

        // Reset mid-frame discards the partial frame
        clear_frame();
        fm[0][2] = 200;
        send_frame(4, 0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", valid_out, 1'b0);
        idle(1);
        clear_frame();
        fm[0][3] = 90;
        model_frame(8, 1);
        send_frame(8, 1, 0);
        idle(3);

        // Metric selection: channel 0 alone vs channel sum
        clear_frame();
        fm[0][2] = 100;
        for (int c = 1; c < CH; c++) fm[c][4] = 90;
`ifdef PDP_MAG_SUM_EN
        push_exp(4, 280, '0);
`else
        push_exp(2, 100, '0);
`endif
        send_frame(8, 1, 0);
        idle(3);

        // Randomized frames
        for (int f = 0; f < 150; f++) begin
            n_beats  = $urandom_range(1, FFT);
            use_last = (n_beats < FFT) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int c = 0; c < CH; c++)
                for (int b = 0; b < FFT; b++) begin
                    fm[c][b] = $urandom_range(0, 12) * 8;
                    fp[c][b] = int'($urandom_range(0, 2 * PIQ - 1)) - PIQ;
                end
            model_frame(n_beats, 1);
            send_frame(n_beats, use_last, 2);
            idle($urandom_range(0, 2));
        end
        idle(10);

        // Final report
        check("queue_empty", exp_q.size(), 0);
        check("overrun_count", overrun_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
